// File: rtl/or1200_alarm_ctrl.sv
// Alarm sequencer for the privilege checker: filters assertion failures,
// stalls the core, raises an alarm interrupt, and locks after repeated trips.
module or1200_alarm_ctrl #(
  parameter int NUM_CHK   = 6,
  parameter int FILTER    = 2,
  parameter int HALT_CYC  = 4,
  parameter int MAX_TRIPS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CHK-1:0] chk_ok,
  input  logic               chk_en,
  input  logic               alarm_ack,
  output logic               cpu_stall,
  output logic               alarm_irq,
  output logic               alarm_locked,
  output logic [NUM_CHK-1:0] fault_src,
  output logic [3:0]         trip_cnt
);

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_HALT   = 2'd1;
  localparam logic [1:0] ST_SIGNAL = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);
  localparam logic [7:0] HALT_LAST = 8'(HALT_CYC - 1);
  localparam logic [3:0] TRIP_LIM  = 4'(MAX_TRIPS);

  logic [1:0]         state, state_n;
  logic [3:0]         filt_cnt, filt_n;
  logic [7:0]         halt_cnt, halt_n;
  logic [NUM_CHK-1:0] fault_n;
  logic [3:0]         trip_n;
  logic               fail;
  logic [NUM_CHK-1:0] new_faults;

  assign fail       = chk_en & ~(&chk_ok);
  assign new_faults = chk_en ? ~chk_ok : '0;

  always_comb begin
    state_n = state;
    filt_n  = filt_cnt;
    halt_n  = halt_cnt;
    fault_n = fault_src;
    trip_n  = trip_cnt;
    case (state)
      ST_ARMED: begin
        if (fail) begin
          fault_n = fault_src | ~chk_ok;
          if (filt_cnt == FILT_LAST) begin
            state_n = ST_HALT;
            filt_n  = 4'd0;
            halt_n  = 8'd0;
            trip_n  = (trip_cnt == 4'hF) ? trip_cnt : trip_cnt + 4'd1;
          end else begin
            filt_n = filt_cnt + 4'd1;
          end
        end else begin
          // An aborted window (or disabled checking) discards recorded faults.
          filt_n  = 4'd0;
          fault_n = '0;
        end
      end
      ST_HALT: begin
        fault_n = fault_src | new_faults;
        halt_n  = halt_cnt + 8'd1;
        if (halt_cnt == HALT_LAST) begin
          state_n = (trip_cnt >= TRIP_LIM) ? ST_LOCKED : ST_SIGNAL;
        end
      end
      ST_SIGNAL: begin
        fault_n = fault_src | new_faults;
        if (alarm_ack) begin
          state_n = ST_ARMED;
          fault_n = '0;
          filt_n  = 4'd0;
        end
      end
      default: begin
        fault_n = fault_src | new_faults;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ARMED;
      filt_cnt     <= 4'd0;
      halt_cnt     <= 8'd0;
      fault_src    <= '0;
      trip_cnt     <= 4'd0;
      cpu_stall    <= 1'b0;
      alarm_irq    <= 1'b0;
      alarm_locked <= 1'b0;
    end else begin
      state        <= state_n;
      filt_cnt     <= filt_n;
      halt_cnt     <= halt_n;
      fault_src    <= fault_n;
      trip_cnt     <= trip_n;
      // Status flags are registered from the next state so they track it exactly.
      cpu_stall    <= (state_n != ST_ARMED);
      alarm_irq    <= (state_n == ST_SIGNAL) || (state_n == ST_LOCKED);
      alarm_locked <= (state_n == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_or1200_alarm_ctrl.sv
// Bench for or1200_alarm_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a cycle-count based reference model.
module tb_or1200_alarm_ctrl;

  localparam int N         = 6;
  localparam int FILTER    = 2;
  localparam int HALT_CYC  = 4;
  localparam int MAX_TRIPS = 3;
  localparam logic [N-1:0] ALL_OK = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] chk_ok;
  logic         chk_en;
  logic         alarm_ack;
  logic         cpu_stall;
  logic         alarm_irq;
  logic         alarm_locked;
  logic [N-1:0] fault_src;
  logic [3:0]   trip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an alarm episode starts at a trip, the interrupt is due
  // HALT_CYC edges after the episode starts, and only an ack taken while the
  // interrupt is already up (and not locked) ends the episode.
  int           m_edges;
  int           m_streak;
  bit           m_alarm;
  int           m_start;
  int           m_trips;
  logic [N-1:0] m_fault;

  or1200_alarm_ctrl #(
    .NUM_CHK(N), .FILTER(FILTER), .HALT_CYC(HALT_CYC), .MAX_TRIPS(MAX_TRIPS)
  ) dut (
    .clk(clk), .rst(rst), .chk_ok(chk_ok), .chk_en(chk_en), .alarm_ack(alarm_ack),
    .cpu_stall(cpu_stall), .alarm_irq(alarm_irq), .alarm_locked(alarm_locked),
    .fault_src(fault_src), .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_irq();
    return m_alarm && (m_edges >= m_start + HALT_CYC);
  endfunction

  task automatic model_clear();
    m_edges  = 0;
    m_streak = 0;
    m_alarm  = 0;
    m_start  = 0;
    m_trips  = 0;
    m_fault  = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] ok, input logic en, input logic ack);
    bit fail;
    fail = en && (ok != ALL_OK);
    if (!m_alarm) begin
      if (fail) begin
        m_streak++;
        m_fault |= ~ok;
        if (m_streak == FILTER) begin
          m_alarm  = 1;
          m_start  = m_edges + 1;
          m_trips  = (m_trips < 15) ? m_trips + 1 : 15;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
        m_fault  = '0;
      end
    end else begin
      bit ack_ok;
      ack_ok = m_irq() && (m_trips < MAX_TRIPS) && ack;
      if (en) m_fault |= ~ok;
      if (ack_ok) begin
        m_alarm  = 0;
        m_fault  = '0;
        m_streak = 0;
      end
    end
    m_edges++;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".stall"},  32'(cpu_stall),    32'(m_alarm));
    check({tag, ".irq"},    32'(alarm_irq),    32'(m_irq()));
    check({tag, ".locked"}, 32'(alarm_locked), 32'(m_irq() && (m_trips >= MAX_TRIPS)));
    check({tag, ".fault"},  32'(fault_src),    32'(m_fault));
    check({tag, ".trips"},  32'(trip_cnt),     32'(m_trips));
  endtask

  task automatic step(input logic [N-1:0] ok, input logic en, input logic ack);
    chk_ok    = ok;
    chk_en    = en;
    alarm_ack = ack;
    @(posedge clk);
    model_edge(ok, en, ack);
    #1;
    compare_all("step");
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    chk_ok    = N'($urandom);
    chk_en    = 1'($urandom);
    alarm_ack = 1'($urandom);
    @(posedge clk);
    model_clear();
    #1;
    check("rst.stall",  32'(cpu_stall),    32'd0);
    check("rst.irq",    32'(alarm_irq),    32'd0);
    check("rst.locked", 32'(alarm_locked), 32'd0);
    check("rst.fault",  32'(fault_src),    32'd0);
    check("rst.trips",  32'(trip_cnt),     32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    chk_ok    = ALL_OK;
    chk_en    = 1'b1;
    alarm_ack = 1'b0;
    model_clear();
    do_reset();

    // Glitch filter: one failing cycle must not trip.
    step(6'b111110, 1, 0);
    for (int i = 0; i < 3; i++) step(ALL_OK, 1, 0);
    check("glitch.stall", 32'(cpu_stall), 32'd0);
    check("glitch.fault", 32'(fault_src), 32'd0);
    check("glitch.trips", 32'(trip_cnt),  32'd0);

    // Normal trip: stall two edges after the first failure, irq four later.
    step(6'b101111, 1, 0);
    check("trip.nostall_yet", 32'(cpu_stall), 32'd0);
    step(6'b101111, 1, 0);
    check("trip.stall", 32'(cpu_stall), 32'd1);
    for (int i = 0; i < 3; i++) step(ALL_OK, 1, 0);
    check("trip.irq_early", 32'(alarm_irq), 32'd0);
    step(ALL_OK, 1, 0);
    check("trip.irq",   32'(alarm_irq), 32'd1);
    check("trip.fault", 32'(fault_src), 32'(6'b010000));
    check("trip.trips", 32'(trip_cnt),  32'd1);
    step(ALL_OK, 1, 1);
    check("ack.stall", 32'(cpu_stall), 32'd0);
    check("ack.irq",   32'(alarm_irq), 32'd0);
    check("ack.fault", 32'(fault_src), 32'd0);

    // Accumulation of a new failure while halted.
    step(6'b111110, 1, 0);
    step(6'b111110, 1, 0);
    step(6'b110111, 1, 0);
    for (int i = 0; i < 3; i++) step(ALL_OK, 1, 0);
    check("accum.irq",   32'(alarm_irq), 32'd1);
    check("accum.fault", 32'(fault_src), 32'(6'b001001));
    step(ALL_OK, 1, 1);

    // Third trip locks; acks are then ignored.
    step(6'b011111, 1, 0);
    step(6'b011111, 1, 0);
    for (int i = 0; i < 4; i++) step(ALL_OK, 1, 0);
    check("lock.locked", 32'(alarm_locked), 32'd1);
    check("lock.trips",  32'(trip_cnt),     32'd3);
    for (int i = 0; i < 3; i++) step(ALL_OK, 1, 1);
    check("lock.hold", 32'({alarm_locked, alarm_irq, cpu_stall}), 32'(3'b111));

    // Reset out of LOCKED, then a lone failing cycle must not trip.
    do_reset();
    step(6'b000000, 1, 0);
    step(ALL_OK, 1, 0);
    step(ALL_OK, 1, 0);
    check("relock.stall", 32'(cpu_stall), 32'd0);

    // Enable gating, then trip and reset while halted.
    for (int i = 0; i < 20; i++) step(6'b000000, 0, 0);
    check("gate.stall", 32'(cpu_stall), 32'd0);
    check("gate.trips", 32'(trip_cnt),  32'd0);
    step(6'b000000, 1, 0);
    step(6'b000000, 1, 0);
    check("gate.stall_on", 32'(cpu_stall), 32'd1);
    step(ALL_OK, 1, 0);
    do_reset();
    step(6'b111101, 1, 0);
    step(ALL_OK, 1, 0);
    check("rehalt.stall", 32'(cpu_stall), 32'd0);
    check("rehalt.trips", 32'(trip_cnt),  32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic [N-1:0] ok;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        ok = ALL_OK;
        if ($urandom_range(0, 3) == 0) ok = N'($urandom);
        step(ok, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
